gray_step_decoder: RTL
======================

Name: gray_step_decoder

Overview:
- Receive-side companion to the Gray-code counter FSM.
- Accepts an asynchronous W-bit Gray-coded position bus, for example from a Gray counter in another clock domain or an absolute encoder.
- Synchronizes the bus, decodes it to binary and classifies each change as step up, step down or illegal jump.
- Keeps a signed running position and a saturating error count for the lab's display and LED logic.

Parameters:
W  3  width of Gray input and decoded binary (W >= 2)
CNT_W  8  width of position counter (two's complement)
ERR_W  4  width of saturating error counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-low (asserted when 0)
g_in  input  W  Gray-coded position, asynchronous to clk
en  input  1  1 = count steps; 0 = track reference only
clr  input  1  synchronous clear of pos and err_cnt
bin_out  output  W  binary decode of synchronized Gray value
step_up  output  1  one-cycle pulse, legal +1 step counted
step_dn  output  1  one-cycle pulse, legal -1 step counted
err  output  1  one-cycle pulse, illegal jump detected
dir  output  1  last legal direction (1 = up, 0 = down)
pos  output  CNT_W  signed running position
err_cnt  output  ERR_W  count of illegal jumps, saturating
ready  output  1  high once state is TRACK

Behaviour:
- Reset (rst=0, async): sync1/sync2/prev = 0, state = FILL0. All outputs 0: bin_out, step_up, step_dn, err, dir, pos, err_cnt, ready.
- Synchronizer: two flops, sync1 <= g_in, sync2 <= sync1. No other logic reads g_in.
- Decode: bin[W-1] = g[W-1]; bin[i] = bin[i+1] ^ g[i]. This is combinational on sync2. bin_out is registered: bin_out <= decode(sync2) every cycle after reset.
- FSM:
  - FILL0 -> FILL1 -> TRACK, one cycle each. Lets the synchronizer fill.
  - On the FILL1 -> TRACK edge, prev <= decode(sync2). No pulses are generated.
  - ready = 1 only in TRACK.
  - TRACK stays in TRACK until reset.
- TRACK, every edge, with d = (decode(sync2) - prev) mod 2^W:
  - d = 0: no pulse.
  - d = 1: step_up pulse if en; pos <= pos + 1; dir <= 1.
  - d = 2^W-1: step_dn pulse if en; pos <= pos - 1; dir <= 0.
  - Any other d: err pulse if en; err_cnt <= err_cnt + 1, saturating at 2^ERR_W-1; pos and dir unchanged.
  - prev <= decode(sync2) unconditionally, regardless of en, so re-enabling causes no spurious step.
- Enable: en = 0 suppresses all pulses and all pos, dir and err_cnt updates.
- Latency: a g_in value captured at edge E0 appears at sync2 at E1. bin_out and the pulses update at E2, and pulses are high for exactly one cycle after E2.
- Position arithmetic: pos wraps modulo 2^CNT_W in two's complement (127 + 1 = -128 for CNT_W = 8), with no saturation.
- Clear: clr = 1 sets pos = 0 and err_cnt = 0 at the next edge, and has priority over a simultaneous step or error. Pulses and dir still update normally that cycle.
- Step pulses: step_up, step_dn and err are mutually exclusive.
- Reset mid-operation: outputs clear immediately (async). After release, FILL0 and FILL1 run again (2 cycles) before any counting.
- Gray wrap: 100 -> 000 (bin 7 -> 0) is a legal +1; 000 -> 100 is a legal -1.

Test Plan:
1. Reset, g_in = 000, en = 1, hold 3 cycles -> ready rises on the 3rd edge after rst release, no pulses, pos = 0, bin_out = 0.
2. Up sweep, g_in = 001, 011, 010, 110, 111, 101, 100, 000, one value per 4 cycles -> 8 step_up pulses, each 2 edges after capture. bin_out = 1..7 then 0. pos = 8, dir = 1, err_cnt = 0.
3. Down sweep, reverse order from 000 (next 100) for 8 values -> 8 step_dn pulses, pos returns to 0, dir = 0.
4. Illegal jumps, 000 -> 010 (bin 3) then 16 further legal/illegal alternations with 17 illegal jumps in total -> err pulse on each illegal jump, pos unchanged on each, err_cnt saturates at 15.
5. en = 0 while g_in steps 000 -> 001 -> 011, then en = 1 -> no pulses, pos unchanged. The first legal step after re-enable (011 -> 010) gives exactly one step_up.
6. pos = 127 with a step_up in the same cycle as clr = 1 -> pos = 0 and step_up still pulses. Separately, with pos = 127 and no clr, one step_up -> pos = -128. Async rst = 0 mid-sweep -> all outputs 0 immediately.

Source files
------------

// File: rtl/gray_step_decoder.sv
// Gray-coded position receiver: synchronizes an asynchronous Gray bus, decodes
// it to binary, classifies each change as +1 / -1 / illegal jump, and keeps a
// signed running position plus a saturating illegal-jump count.
module gray_step_decoder #(
   parameter int unsigned W     = 3,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned ERR_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     g_in,
   input  logic             en,
   input  logic             clr,
   output logic [W-1:0]     bin_out,
   output logic             step_up,
   output logic             step_dn,
   output logic             err,
   output logic             dir,
   output logic [CNT_W-1:0] pos,
   output logic [ERR_W-1:0] err_cnt,
   output logic             ready
);

   localparam logic [1:0] FILL0 = 2'd0;
   localparam logic [1:0] FILL1 = 2'd1;
   localparam logic [1:0] TRACK = 2'd2;

   localparam logic [W-1:0]     STEP_FWD = W'(1);
   localparam logic [W-1:0]     STEP_BWD = '1;
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   logic [W-1:0]     sync1;
   logic [W-1:0]     sync2;
   logic [W-1:0]     prev;
   logic [1:0]       state;

   logic [W-1:0]     dec;
   logic [W-1:0]     delta;

   logic [1:0]       state_nxt;
   logic [W-1:0]     prev_nxt;
   logic             step_up_nxt;
   logic             step_dn_nxt;
   logic             err_nxt;
   logic             dir_nxt;
   logic [CNT_W-1:0] pos_nxt;
   logic [ERR_W-1:0] err_cnt_nxt;
   logic             ready_nxt;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
      logic [W-1:0] b;
      b[W-1] = g[W-1];
      for (int i = int'(W) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign dec   = gray2bin(sync2);
   assign delta = dec - prev;

   // Two-flop synchronizer and registered binary decode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1   <= '0;
         sync2   <= '0;
         bin_out <= '0;
      end else begin
         sync1   <= g_in;
         sync2   <= sync1;
         bin_out <= dec;
      end
   end

   // Next-state, step classification and counter updates.
   always_comb begin
      state_nxt   = state;
      prev_nxt    = prev;
      step_up_nxt = 1'b0;
      step_dn_nxt = 1'b0;
      err_nxt     = 1'b0;
      dir_nxt     = dir;
      pos_nxt     = pos;
      err_cnt_nxt = err_cnt;
      ready_nxt   = (state == TRACK);

      case (state)
         FILL0: begin
            state_nxt = FILL1;
         end
         FILL1: begin
            state_nxt = TRACK;
            prev_nxt  = dec;
         end
         TRACK: begin
            // Reference always follows the input so re-enabling causes no step.
            prev_nxt = dec;
            if (en && (delta != '0)) begin
               if (delta == STEP_FWD) begin
                  step_up_nxt = 1'b1;
                  pos_nxt     = pos + CNT_W'(1);
                  dir_nxt     = 1'b1;
               end else if (delta == STEP_BWD) begin
                  step_dn_nxt = 1'b1;
                  pos_nxt     = pos - CNT_W'(1);
                  dir_nxt     = 1'b0;
               end else begin
                  err_nxt = 1'b1;
                  if (err_cnt != ERR_MAX) begin
                     err_cnt_nxt = err_cnt + ERR_W'(1);
                  end
               end
            end
         end
         default: begin
            state_nxt = FILL0;
         end
      endcase

      // Clear wins over a same-cycle step or error; pulses and dir unaffected.
      if (clr) begin
         pos_nxt     = '0;
         err_cnt_nxt = '0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= FILL0;
         prev    <= '0;
         step_up <= 1'b0;
         step_dn <= 1'b0;
         err     <= 1'b0;
         dir     <= 1'b0;
         pos     <= '0;
         err_cnt <= '0;
         ready   <= 1'b0;
      end else begin
         state   <= state_nxt;
         prev    <= prev_nxt;
         step_up <= step_up_nxt;
         step_dn <= step_dn_nxt;
         err     <= err_nxt;
         dir     <= dir_nxt;
         pos     <= pos_nxt;
         err_cnt <= err_cnt_nxt;
         ready   <= ready_nxt;
      end
   end

endmodule
